// File: rtl/dvi_timing_controller.sv
// dvi_timing_controller
//
// Raster timing generator and pixel sequencer for the three TMDS encoders of
// the DVI/HDMI transmitter. Pulls pixels from an upstream valid/ready stream
// during the active region and presents them on data_* aligned to de.
// All logic runs on clk_pixel.
//
// Ports:
//   clk_pixel      in   pixel clock
//   reset_n        in   asynchronous active-low reset
//   enable         in   raster run enable; low holds the raster at (0,0)
//   pattern_sel    in   (DVI_TIMING_TEST_PATTERN_EN only) colour-bar select
//   s_pixel_data   in   upstream pixel {R,G,B}
//   s_pixel_valid  in   upstream pixel valid
//   s_pixel_ready  out  pixel accepted this cycle (combinational)
//   de             out  data enable to all encoders
//   ctl0           out  blue channel ctl = {vsync, hsync}
//   ctl1, ctl2     out  tied to 2'b00
//   data_b/g/r     out  encoder data
//   frame_start    out  pulse alongside the first active pixel of a frame
//   underflow      out  sticky: an active slot found no valid pixel
//
// Build option: define DVI_TIMING_TEST_PATTERN_EN to add the pattern_sel
// input and the internal 8-bar colour pattern source.
//
// State table (horizontal / vertical FSMs):
//   H_ACT | active pixels of the line       V_ACT | active lines
//   H_FP  | horizontal front porch          V_FP  | vertical front porch
//   H_SY  | hsync asserted                  V_SY  | vsync asserted
//   H_BP  | horizontal back porch           V_BP  | vertical back porch

module dvi_timing_controller #(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   CNT_W     = 12
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        enable,
`ifdef DVI_TIMING_TEST_PATTERN_EN
   input  logic        pattern_sel,
`endif
   input  logic [23:0] s_pixel_data,
   input  logic        s_pixel_valid,
   output logic        s_pixel_ready,
   output logic        de,
   output logic [1:0]  ctl0,
   output logic [1:0]  ctl1,
   output logic [1:0]  ctl2,
   output logic [7:0]  data_b,
   output logic [7:0]  data_g,
   output logic [7:0]  data_r,
   output logic        frame_start,
   output logic        underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // last counter value of each region
   localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] H_FP_END  = CNT_W'(H_ACTIVE + H_FRONT - 1);
   localparam logic [CNT_W-1:0] H_SY_END  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] H_BP_END  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_FP_END  = CNT_W'(V_ACTIVE + V_FRONT - 1);
   localparam logic [CNT_W-1:0] V_SY_END  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
   localparam logic [CNT_W-1:0] V_BP_END  = CNT_W'(V_TOTAL - 1);

   typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

   h_state_t         h_state, h_state_nxt;
   v_state_t         v_state, v_state_nxt;
   logic [CNT_W-1:0] h_cnt, h_cnt_nxt;
   logic [CNT_W-1:0] v_cnt, v_cnt_nxt;
   logic             line_end;
   logic             frame_end;
   logic             slot;
   logic             use_pattern;
   logic [23:0]      pix_nxt;

   assign line_end  = (h_cnt == H_BP_END);
   assign frame_end = (v_cnt == V_BP_END);

   // ------------------------------------------------------------------
   // raster state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         h_state <= H_ACT;
         v_state <= V_ACT;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         h_state <= h_state_nxt;
         v_state <= v_state_nxt;
         h_cnt   <= h_cnt_nxt;
         v_cnt   <= v_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // next-state: the FSMs advance on the last count of each region, the
   // vertical one only on the line wrap. enable low parks everything at
   // slot (0,0) so the first enabled cycle is the first active pixel.
   // ------------------------------------------------------------------
   always_comb begin
      h_state_nxt = h_state;
      v_state_nxt = v_state;
      h_cnt_nxt   = h_cnt;
      v_cnt_nxt   = v_cnt;
      if (!enable) begin
         h_state_nxt = H_ACT;
         v_state_nxt = V_ACT;
         h_cnt_nxt   = '0;
         v_cnt_nxt   = '0;
      end else begin
         h_cnt_nxt = line_end ? '0 : h_cnt + 1'b1;
         case (h_state)
            H_ACT:   if (h_cnt == H_ACT_END) h_state_nxt = H_FP;
            H_FP:    if (h_cnt == H_FP_END)  h_state_nxt = H_SY;
            H_SY:    if (h_cnt == H_SY_END)  h_state_nxt = H_BP;
            H_BP:    if (h_cnt == H_BP_END)  h_state_nxt = H_ACT;
            default: h_state_nxt = H_ACT;
         endcase
         if (line_end) begin
            v_cnt_nxt = frame_end ? '0 : v_cnt + 1'b1;
            case (v_state)
               V_ACT:   if (v_cnt == V_ACT_END) v_state_nxt = V_FP;
               V_FP:    if (v_cnt == V_FP_END)  v_state_nxt = V_SY;
               V_SY:    if (v_cnt == V_SY_END)  v_state_nxt = V_BP;
               V_BP:    if (v_cnt == V_BP_END)  v_state_nxt = V_ACT;
               default: v_state_nxt = V_ACT;
            endcase
         end
      end
   end

   assign slot = enable && (h_state == H_ACT) && (v_state == V_ACT);

`ifdef DVI_TIMING_TEST_PATTERN_EN
   localparam logic [CNT_W+2:0] BAR_DIV = (CNT_W + 3)'(H_ACTIVE);
   logic [2:0]  bar_idx;
   logic [23:0] bar_rgb;

   assign use_pattern = pattern_sel;
   assign bar_idx     = 3'(({3'b000, h_cnt} << 3) / BAR_DIV);

   always_comb begin
      bar_rgb = 24'h000000;
      case (bar_idx)
         3'd0: bar_rgb = 24'hFFFFFF;
         3'd1: bar_rgb = 24'hFFFF00;
         3'd2: bar_rgb = 24'h00FFFF;
         3'd3: bar_rgb = 24'h00FF00;
         3'd4: bar_rgb = 24'hFF00FF;
         3'd5: bar_rgb = 24'hFF0000;
         3'd6: bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end
`else
   assign use_pattern = 1'b0;
`endif

   // reset_n gating keeps ready low while reset is held, since the counters
   // sit at (0,0), which is itself an active slot.
   assign s_pixel_ready = reset_n && slot && !use_pattern;

   always_comb begin
      pix_nxt = 24'h000000;
      if (slot) begin
`ifdef DVI_TIMING_TEST_PATTERN_EN
         if (use_pattern)
            pix_nxt = bar_rgb;
         else if (s_pixel_valid)
            pix_nxt = s_pixel_data;
`else
         if (s_pixel_valid)
            pix_nxt = s_pixel_data;
`endif
      end
   end

   // ------------------------------------------------------------------
   // registered outputs, one cycle behind the raster state
   // ------------------------------------------------------------------
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         de          <= 1'b0;
         data_r      <= 8'h00;
         data_g      <= 8'h00;
         data_b      <= 8'h00;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         ctl0        <= {~VSYNC_POL, ~HSYNC_POL};
      end else begin
         de                       <= slot;
         {data_r, data_g, data_b} <= pix_nxt;
         frame_start              <= enable && (h_cnt == '0) && (v_cnt == '0);
         ctl0[0] <= (enable && (h_state == H_SY)) ? HSYNC_POL : ~HSYNC_POL;
         ctl0[1] <= (enable && (v_state == V_SY)) ? VSYNC_POL : ~VSYNC_POL;
         if (!enable)
            underflow <= 1'b0;
         else if (s_pixel_ready && !s_pixel_valid)
            underflow <= 1'b1;
      end
   end

   assign ctl1 = 2'b00;
   assign ctl2 = 2'b00;

endmodule

// File: tb/tb_dvi_timing_controller.sv
// Testbench for dvi_timing_controller with a small 8x6 raster.
// A position-based model (linear slot index within the frame) predicts every
// output each cycle; directed scenarios add hand-computed literal checks.

module tb_dvi_timing_controller;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic        clk_pixel = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [23:0] s_pixel_data;
   logic        s_pixel_valid;
   logic        s_pixel_ready;
   logic        de;
   logic [1:0]  ctl0, ctl1, ctl2;
   logic [7:0]  data_b, data_g, data_r;
   logic        frame_start;
   logic        underflow;

   int checks = 0;
   int fails  = 0;

   always #5 clk_pixel = ~clk_pixel;

   dvi_timing_controller #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(12)
   ) u_dut (
      .clk_pixel     (clk_pixel),
      .reset_n       (reset_n),
      .enable        (enable),
`ifdef DVI_TIMING_TEST_PATTERN_EN
      .pattern_sel   (1'b0),
`endif
      .s_pixel_data  (s_pixel_data),
      .s_pixel_valid (s_pixel_valid),
      .s_pixel_ready (s_pixel_ready),
      .de            (de),
      .ctl0          (ctl0),
      .ctl1          (ctl1),
      .ctl2          (ctl2),
      .data_b        (data_b),
      .data_g        (data_g),
      .data_r        (data_r),
      .frame_start   (frame_start),
      .underflow     (underflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // model: pos is the linear slot index of the current cycle
   // ------------------------------------------------------------------
   int          pos = 0;
   logic        e_de, e_fs, e_uf;
   logic [23:0] e_data;
   logic [1:0]  e_ctl0;
   int          cnt_de, cnt_fs, cnt_hs, cnt_vs;

   always @(negedge clk_pixel) begin
      int  h, v;
      bit  act;
      if (!reset_n) begin
         pos    = 0;
         e_de   = 1'b0;
         e_fs   = 1'b0;
         e_uf   = 1'b0;
         e_data = 24'h0;
         e_ctl0 = 2'b11;
      end else begin
         check("de",          de, e_de);
         check("data",        {data_r, data_g, data_b}, e_data);
         check("frame_start", frame_start, e_fs);
         check("underflow",   underflow, e_uf);
         check("ctl0",        ctl0, e_ctl0);
         check("ctl1",        ctl1, 2'b00);
         check("ctl2",        ctl2, 2'b00);
         h   = pos % HT;
         v   = pos / HT;
         act = enable && (h < HA) && (v < VA);
         check("ready", s_pixel_ready, act);
         e_de      = act;
         e_data    = (act && s_pixel_valid) ? s_pixel_data : 24'h0;
         e_fs      = enable && (pos == 0);
         e_ctl0[0] = !(enable && h >= HA + HF && h < HA + HF + HS);
         e_ctl0[1] = !(enable && v >= VA + VF && v < VA + VF + VS);
         if (!enable)                    e_uf = 1'b0;
         else if (act && !s_pixel_valid) e_uf = 1'b1;
         pos = enable ? (pos + 1) % (HT * VT) : 0;
         cnt_de += int'(de);
         cnt_fs += int'(frame_start);
         cnt_hs += int'(ctl0[0] == 1'b0);
         cnt_vs += int'(ctl0[1] == 1'b0);
      end
   end

`ifdef DVI_TIMING_TEST_PATTERN_EN
   // colour-bar instance: 8 active pixels per line so bar index = h
   localparam int PHA = 8;
   localparam int PHT = PHA + HF + HS + HB;
   logic        p_ready, p_de, p_fs, p_uf;
   logic [1:0]  p_ctl0, p_ctl1, p_ctl2;
   logic [7:0]  p_b, p_g, p_r;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
   int          ppos = 0;
   logic        pe_de;
   logic [23:0] pe_data;

   dvi_timing_controller #(
      .H_ACTIVE(PHA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(12)
   ) u_pat (
      .clk_pixel     (clk_pixel),
      .reset_n       (reset_n),
      .enable        (enable),
      .pattern_sel   (1'b1),
      .s_pixel_data  (s_pixel_data),
      .s_pixel_valid (s_pixel_valid),
      .s_pixel_ready (p_ready),
      .de            (p_de),
      .ctl0          (p_ctl0),
      .ctl1          (p_ctl1),
      .ctl2          (p_ctl2),
      .data_b        (p_b),
      .data_g        (p_g),
      .data_r        (p_r),
      .frame_start   (p_fs),
      .underflow     (p_uf)
   );

   always @(negedge clk_pixel) begin
      int h, v;
      bit act;
      if (!reset_n) begin
         ppos    = 0;
         pe_de   = 1'b0;
         pe_data = 24'h0;
      end else begin
         check("pat_de",    p_de, pe_de);
         check("pat_data",  {p_r, p_g, p_b}, pe_data);
         check("pat_ready", p_ready, 1'b0);
         check("pat_uf",    p_uf, 1'b0);
         h       = ppos % PHT;
         v       = ppos / PHT;
         act     = enable && (h < PHA) && (v < VA);
         pe_de   = act;
         pe_data = act ? bars[h] : 24'h0;
         ppos    = enable ? (ppos + 1) % (PHT * VT) : 0;
      end
   end
`endif

   // ------------------------------------------------------------------
   // stimulus
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk_pixel);
      #1;
      s_pixel_data = s_pixel_data + 24'h010203;
   endtask

   task automatic wait_pos(input int target);
      int n = 0;
      while (pos != target && n < 200) begin
         step();
         n++;
      end
      check("wait_pos", pos, target);
   endtask

   initial begin
      reset_n       = 1'b0;
      enable        = 1'b1;
      s_pixel_valid = 1'b1;
      s_pixel_data  = 24'h000000;
      repeat (3) step();

      // reset values
      check("rst_de",    de, 1'b0);
      check("rst_ctl0",  ctl0, 2'b11);
      check("rst_ready", s_pixel_ready, 1'b0);
      check("rst_uf",    underflow, 1'b0);
      reset_n = 1'b1;

      // two full frames of free running
      repeat (4) step();
      cnt_de = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0;
      repeat (96) step();
      check("cnt_de_96",    cnt_de, 24);
      check("cnt_fs_96",    cnt_fs, 2);
      check("cnt_hsync_96", cnt_hs, 24);
      check("cnt_vsync_96", cnt_vs, 16);
      check("uf_clean",     underflow, 1'b0);

      // starve pixel (2,1)
      wait_pos(1 * HT + 2);
      s_pixel_valid = 1'b0;
      @(negedge clk_pixel);
      check("uf_ready", s_pixel_ready, 1'b1);
      step();
      s_pixel_valid = 1'b1;
      @(negedge clk_pixel);
      check("uf_de",    de, 1'b1);
      check("uf_black", {data_r, data_g, data_b}, 24'h0);
      check("uf_set",   underflow, 1'b1);
      repeat (20) step();
      check("uf_sticky", underflow, 1'b1);

      // drop enable at (3,1) for 5 cycles
      wait_pos(1 * HT + 3);
      enable = 1'b0;
      @(negedge clk_pixel);
      check("dis_ready", s_pixel_ready, 1'b0);
      @(negedge clk_pixel);
      check("dis_de",   de, 1'b0);
      check("dis_ctl0", ctl0, 2'b11);
      check("dis_uf",   underflow, 1'b0);
      repeat (3) @(negedge clk_pixel);
      step();
      enable = 1'b1;
      @(negedge clk_pixel);
      check("ren_ready", s_pixel_ready, 1'b1);
      @(negedge clk_pixel);
      check("ren_fs", frame_start, 1'b1);
      check("ren_de", de, 1'b1);

      // async reset in the middle of an active line
      wait_pos(2);
      check("pre_rst_de", de, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check("arst_de",    de, 1'b0);
      check("arst_data",  {data_r, data_g, data_b}, 24'h0);
      check("arst_fs",    frame_start, 1'b0);
      check("arst_uf",    underflow, 1'b0);
      check("arst_ctl0",  ctl0, 2'b11);
      check("arst_ready", s_pixel_ready, 1'b0);
      repeat (3) step();
      reset_n = 1'b1;
      repeat (60) step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/dvi_timing_controller.md
# dvi_timing_controller

- Sequences the three per-channel TMDS encoders of the DVI/HDMI transmitter.
- Generates the horizontal/vertical raster, drives each encoder's `de` and `ctl` inputs, and pulls pixels from an upstream stream with a valid/ready handshake.
- Presents pixels aligned to `de`.
- Sits between the frame source (DMA/pattern logic) and the encoder/serializer stage, all in the pixel clock domain.

## Interface
Parameters:
- `H_ACTIVE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `HSYNC_POL`, 0, asserted hsync level
- `VSYNC_POL`, 0, asserted vsync level
- `CNT_W`, 12, width of h/v counters; must hold total−1

Ports:
- `clk_pixel`  in  1  pixel clock; one clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  raster run enable
- `s_pixel_data`  in  24  upstream pixel {R[23:16],G[15:8],B[7:0]}
- `s_pixel_valid`  in  1  upstream pixel valid
- `s_pixel_ready`  out  1  controller accepts a pixel this cycle
- `de`  out  1  data enable, to all three encoders
- `ctl0`  out  2  channel 0 (blue) ctl = {vsync, hsync}
- `ctl1`  out  2  channel 1 ctl, constant 2'b00
- `ctl2`  out  2  channel 2 ctl, constant 2'b00
- `data_b`, `data_g`, `data_r`  out  8 each  encoder data inputs
- `frame_start`  out  1  one-cycle pulse with first active pixel of a frame
- `underflow`  out  1  sticky: pixel slot found `s_pixel_valid`=0

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL−1 (H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK).
  - `v_cnt` increments when `h_cnt` wraps, 0..V_TOTAL−1.
  - Both wrap to 0 at their ends.
- Horizontal FSM, `h_cnt`-driven: H_ACT → H_FP → H_SY → H_BP → H_ACT. Vertical FSM V_ACT → V_FP → V_SY → V_BP → V_ACT, advancing only on line wrap.
- Raster order:
  - Each line is active region first, then front porch, sync, back porch.
  - Frames use the same order over lines.
- Active region = H_ACT ∧ V_ACT.
- `s_pixel_ready` (combinational from counters) = `enable` ∧ active region.
- Pixel slot:
  - Valid∧ready: the pixel is registered onto `data_*` with `de`=1 next cycle.
  - Ready∧!valid: outputs black (0,0,0) with `de`=1; set `underflow`.
  - The raster never stalls.
- Sync levels:
  - hsync is asserted at HSYNC_POL during H_SY, on every line including vertical blanking.
  - vsync is asserted at VSYNC_POL for the whole lines in V_SY; it changes only at `h_cnt`=0.
- Outputs outside active region: `de`=0, `data_*`=0.
- `underflow` clears only on reset or `enable` low.
- `enable`=0:
  - counters held at (0,0), `s_pixel_ready`=0, `de`=0
  - `ctl0` = both syncs inactive, `frame_start`=0
- `enable` rising: the first cycle with `enable`=1 is slot (0,0).
- Deasserting `enable` mid-frame resets the raster to (0,0) next cycle; no partial-frame completion.

## Timing
- Reset (async assert, sync deassert handled externally):
  - `de`=0, `data_*`=0, `frame_start`=0, `underflow`=0, `s_pixel_ready`=0
  - `ctl0`={~VSYNC_POL,~HSYNC_POL}, `ctl1`=`ctl2`=2'b00
  - counters=0
- Latency: all outputs except `s_pixel_ready` are registered, exactly 1 cycle after the counter state that produces them. A pixel accepted at cycle t appears on `data_*` at t+1 with `de`=1.
- `frame_start`: high at t+1 for counter state (0,0) only.
- `ctl1`/`ctl2` are tied to 2'b00.

## Configuration
- `DVI_TIMING_TEST_PATTERN_EN` defined:
  - Adds input `pattern_sel` (1 bit).
  - When 1, every active slot outputs 8 vertical color bars and `s_pixel_ready` is held 0, so there are no handshakes and no underflow.
  - Bar index = `h_cnt`*8/H_ACTIVE; colors in order white, yellow, cyan, green, magenta, red, blue, black.
  - Component levels are 0xFF/0x00.
- Not defined: no `pattern_sel` port; pixels always come from the stream.

## Test plan
Bench parameters: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), pol 0.

- Reset released with `enable`=1, source always valid, incrementing data → `de` high 4 of every 8 cycles on lines 0–2.
  - `data_*` equals the accepted pixel one cycle later.
  - `frame_start` every 48 cycles.
- Sync check → `ctl0[0]`=0 at `h_cnt` 5–6 (seen one cycle later) on all 6 lines; `ctl0[1]`=0 for all 8 cycles of line 4.
- `s_pixel_valid`=0 at pixel (2,1) → black on that slot, `underflow`=1 and stays 1; raster timing unchanged.
- `enable` dropped at (3,1) for 5 cycles → `de`=0, `ctl0`=2'b11, `s_pixel_ready`=0; restart gives `frame_start` and pixel (0,0) one cycle after re-enable.
- `reset_n` asserted mid-active line → all outputs at reset values immediately, without a clock edge.
- With `DVI_TIMING_TEST_PATTERN_EN` and `pattern_sel`=1, H_ACTIVE=8 → active pixels show bars 0xFFFFFF, 0xFFFF00, 0x00FFFF, 0x00FF00, 0xFF00FF, 0xFF0000, 0x0000FF, 0x000000; `s_pixel_ready`=0 throughout.
